mx_rr_sel: RTL and testbench
============================

Name: mx_rr_sel

Overview:
- Parametrised successor to the fixed 8:1 4-bit mux.
- Selects one of CH input channels of WIDTH bits each and registers the selection into an output stage with valid/ready handshake.
- Selection is either by an explicit select code (fixed mode) or by round-robin arbitration among requesting channels (rr mode).
- Sits between multiple producer blocks and a single consumer in the datapath.

Parameters:
- WIDTH, 4, data bits per channel (>=1)
- CH, 8, number of input channels (2..2**SEL_W)
- SEL_W, 3, width of select code and channel ID; CH <= 2**SEL_W required

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select by sel; 1 = round-robin
- sel  input  SEL_W  channel code used in fixed mode
- in_valid  input  CH  per-channel request; bit i = channel i
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CH  per-channel accept, combinational
- out_valid  output  1  output register holds data
- out_data  output  WIDTH  registered selected data
- out_ch  output  SEL_W  channel ID of out_data
- out_ready  input  1  consumer accepts when high with out_valid

Behaviour:
- Reset (clk edge with reset=1):
  - out_valid=0, out_data=0, out_ch=0.
  - last_grant=CH-1, so channel 0 has first rr priority.
  - Reset overrides any transfer in the same cycle; an in-flight word is discarded.
- load_en = !out_valid || out_ready.
- Fixed mode (mode=0):
  - Candidate is sel.
  - Grant only if sel < CH and in_valid[sel]=1.
  - sel >= CH produces no grant and all in_ready=0.
- RR mode (mode=1):
  - Scan channels from last_grant+1, wrapping CH-1 -> 0.
  - Grant the first channel with in_valid=1; if none valid, no grant.
  - last_grant is also updated by fixed-mode grants.
- Handshake:
  - in_ready[i] = load_en && grant_valid && grant==i.
  - At most one in_ready bit is high in any cycle.
  - An input transfer occurs when in_valid[i] && in_ready[i].
- On transfer:
  - out_data <= channel i data; out_ch <= i; out_valid <= 1; last_grant <= i.
- Else if out_ready=1: out_valid <= 0; out_data and out_ch hold their last values.
- Else (out_valid=1, out_ready=0): all registers hold, in_ready=0 (backpressure).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high; simultaneous drain and load in one cycle is allowed.
- mode/sel changes:
  - Take effect in the next arbitration cycle.
  - Never alter a word already held in the output register.
- in_valid deasserted without a transfer: no state change. Producers must hold data stable until transfer.

Optional Feature:
- Macro: MX_RR_SEL_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], a count of input transfers.
  - Increments by 1 per transfer, saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: reset=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout; after release in rr mode, first grant goes to ch0.
- Fixed mode: mode=0, sel=5, ch5 data=4'hA, all in_valid=8'hFF, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=4'hA, out_ch=5.
- Fixed mode, invalid code: CH=6, SEL_W=3, sel=7 -> in_ready=0 and out_valid stays 0.
- RR fairness: mode=1, in_valid=8'b1001_0010 held, out_ready=1 -> out_ch sequence 1,4,7,1,4,7, one word per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data and out_ch stable, in_ready=0; raise out_ready -> drain and new load in the same cycle.
- Optional feature (MX_RR_SEL_CNT_EN defined): 10 transfers -> xfer_cnt=10; preload counter to 16'hFFFE, apply 3 transfers -> xfer_cnt=16'hFFFF.

Source files
------------

// File: rtl/mx_rr_sel.sv
// Purpose: CH-to-1 channel selector (fixed code or round-robin) into a registered valid/ready output stage.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a held word with out_ready low zeroes in_ready; drain and reload may happen in the same cycle.
// Optional: define MX_RR_SEL_CNT_EN to add a saturating 16-bit transfer counter port xfer_cnt.
module mx_rr_sel #(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [CH-1:0]         in_valid,
    input  logic [CH*WIDTH-1:0]   in_data,
    output logic [CH-1:0]         in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
`ifdef MX_RR_SEL_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_dat;
    logic             load_en;
    logic             xfer;

    assign load_en = !out_valid || out_ready;
    assign xfer    = !reset && load_en && grant_vld;

    // RR picks the requester at the smallest forward distance past last_grant.
    always_comb begin
        int best;
        int dst;
        grant_vld = 1'b0;
        grant     = '0;
        best      = CH;
        dst       = 0;
        if (!mode) begin
            for (int i = 0; i < CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (in_valid[i]) begin
                    dst = (i - int'(last_grant) - 1 + 2 * CH) % CH;
                    if (dst < best) begin
                        best      = dst;
                        grant_vld = 1'b1;
                        grant     = SEL_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready  = '0;
        grant_dat = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_dat   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !reset && load_en && grant_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(CH - 1);
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= grant_dat;
            out_ch     <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef MX_RR_SEL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (xfer && xfer_cnt != 16'hFFFF) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mx_rr_sel.sv
// Bench for mx_rr_sel: vector table, randomized run against a reference model, and a CH=6 instance for invalid codes and wrap.
module tb_mx_rr_sel;

    logic        clk;
    logic        reset, mode, out_ready, out_valid;
    logic [2:0]  sel, out_ch;
    logic [7:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic [3:0]  out_data;

    logic        r6_reset, r6_mode, r6_out_ready, r6_out_valid;
    logic [2:0]  r6_sel, r6_out_ch;
    logic [5:0]  r6_in_valid, r6_in_ready;
    logic [23:0] r6_in_data;
    logic [3:0]  r6_out_data;
`ifdef MX_RR_SEL_CNT_EN
    logic [15:0] xfer_cnt, r6_xfer_cnt;
`endif

    mx_rr_sel #(.WIDTH(4), .CH(8), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
`ifdef MX_RR_SEL_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    mx_rr_sel #(.WIDTH(4), .CH(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(r6_reset), .mode(r6_mode), .sel(r6_sel), .in_valid(r6_in_valid), .in_data(r6_in_data),
        .in_ready(r6_in_ready), .out_valid(r6_out_valid), .out_data(r6_out_data), .out_ch(r6_out_ch),
        .out_ready(r6_out_ready)
`ifdef MX_RR_SEL_CNT_EN
        , .xfer_cnt(r6_xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int         m_last = 7;
    logic       m_ov = 1'b0;
    logic [3:0] m_od = 4'h0;
    logic [2:0] m_oc = 3'd0;
    int         m_cnt = 0;
    logic [7:0] m_ir;
    logic [7:0] act_ir;

    task automatic apply(input logic rst, input logic m, input logic [2:0] s, input logic [7:0] iv,
                         input logic [31:0] dat, input logic ordy);
        logic       load;
        logic [2:0] idx;
        int         g;
        reset = rst; mode = m; sel = s; in_valid = iv; in_data = dat; out_ready = ordy;
        load = !m_ov || ordy;
        g = -1;
        if (!m) begin
            if (iv[s]) g = int'(s);
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = 3'((m_last + k) % 8);
                if (g < 0 && iv[idx]) g = int'(idx);
            end
        end
        m_ir = (!rst && load && g >= 0) ? 8'(1 << g) : 8'h00;
        #2 act_ir = in_ready;
        @(posedge clk);
        if (rst) begin
            m_last = 7; m_ov = 1'b0; m_od = 4'h0; m_oc = 3'd0; m_cnt = 0;
        end else if (m_ir != 8'h00) begin
            m_ov = 1'b1; m_od = dat[g*4 +: 4]; m_oc = 3'(g); m_last = g;
            if (m_cnt < 65535) m_cnt++;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic step6(input logic rst, input logic m, input logic [2:0] s, input logic [5:0] iv,
                         input logic ordy, output logic [5:0] ir);
        r6_reset = rst; r6_mode = m; r6_sel = s; r6_in_valid = iv; r6_out_ready = ordy;
        #2 ir = r6_in_ready;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       m;
        logic [2:0] s;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] ir;
        logic       ov;
        logic [2:0] ch;
        logic [3:0] d;
    } vec_t;

    vec_t tbl[23];
    logic [5:0] ir6;

    initial begin
        // Channel i carries data ~i: ch0=F ... ch5=A ... ch7=8
        tbl[0]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0};
        tbl[1]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 4'hF};
        tbl[3]  = '{1'b0, 1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 4'hA};
        tbl[4]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h80, 1'b1, 3'd7, 4'h8};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h02, 1'b1, 3'd1, 4'hE};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h10, 1'b1, 3'd4, 4'hB};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h80, 1'b1, 3'd7, 4'h8};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h02, 1'b1, 3'd1, 4'hE};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h10, 1'b1, 3'd4, 4'hB};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 8'h92, 1'b1, 8'h80, 1'b1, 3'd7, 4'h8};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 4'h8};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7, 4'h8};
        tbl[13] = '{1'b0, 1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 4'hC};
        tbl[14] = '{1'b0, 1'b0, 3'd2, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 4'hC};
        tbl[15] = '{1'b0, 1'b0, 3'd2, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 4'hC};
        tbl[16] = '{1'b0, 1'b0, 3'd2, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 4'hC};
        tbl[17] = '{1'b0, 1'b0, 3'd2, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 4'hD};
        tbl[18] = '{1'b0, 1'b1, 3'd0, 8'h09, 1'b1, 8'h08, 1'b1, 3'd3, 4'hC};
        tbl[19] = '{1'b0, 1'b1, 3'd0, 8'h09, 1'b1, 8'h01, 1'b1, 3'd0, 4'hF};
        tbl[20] = '{1'b0, 1'b0, 3'd4, 8'hEF, 1'b1, 8'h00, 1'b0, 3'd0, 4'hF};
        tbl[21] = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0};
        tbl[22] = '{1'b0, 1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 4'hF};

        r6_reset = 1'b1; r6_mode = 1'b0; r6_sel = 3'd0; r6_in_valid = 6'h00;
        r6_in_data = 24'hABCDEF; r6_out_ready = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].rst, tbl[i].m, tbl[i].s, tbl[i].iv, 32'h89AB_CDEF, tbl[i].ordy);
            check($sformatf("tbl%0d in_ready", i), 32'(act_ir), 32'(tbl[i].ir));
            check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d out_ch", i), 32'(out_ch), 32'(tbl[i].ch));
            check($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].d));
`ifdef MX_RR_SEL_CNT_EN
            check($sformatf("tbl%0d xfer_cnt", i), 32'(xfer_cnt), 32'(m_cnt));
`endif
        end

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 49) == 0, 1'($urandom), 3'($urandom), 8'($urandom), $urandom,
                  $urandom_range(0, 3) != 0);
            check($sformatf("rnd%0d in_ready", i), 32'(act_ir), 32'(m_ir));
            check($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(m_ov));
            check($sformatf("rnd%0d out_ch", i), 32'(out_ch), 32'(m_oc));
            check($sformatf("rnd%0d out_data", i), 32'(out_data), 32'(m_od));
`ifdef MX_RR_SEL_CNT_EN
            check($sformatf("rnd%0d xfer_cnt", i), 32'(xfer_cnt), 32'(m_cnt));
`endif
        end

        // CH=6: codes 6 and 7 grant nothing; rr wraps from ch5 to ch0
        step6(1'b1, 1'b0, 3'd7, 6'h3F, 1'b1, ir6);
        step6(1'b0, 1'b0, 3'd7, 6'h3F, 1'b1, ir6);
        check("ch6 sel7 in_ready", 32'(ir6), 32'h0);
        check("ch6 sel7 out_valid", 32'(r6_out_valid), 32'h0);
        step6(1'b0, 1'b0, 3'd6, 6'h3F, 1'b1, ir6);
        check("ch6 sel6 in_ready", 32'(ir6), 32'h0);
        check("ch6 sel6 out_valid", 32'(r6_out_valid), 32'h0);
        step6(1'b0, 1'b0, 3'd5, 6'h3F, 1'b1, ir6);
        check("ch6 sel5 in_ready", 32'(ir6), 32'h20);
        check("ch6 sel5 out_ch", 32'(r6_out_ch), 32'd5);
        check("ch6 sel5 out_data", 32'(r6_out_data), 32'hA);
        step6(1'b0, 1'b1, 3'd0, 6'h3F, 1'b1, ir6);
        check("ch6 wrap in_ready", 32'(ir6), 32'h01);
        check("ch6 wrap out_ch", 32'(r6_out_ch), 32'd0);
        check("ch6 wrap out_data", 32'(r6_out_data), 32'hF);
        step6(1'b0, 1'b1, 3'd0, 6'h3F, 1'b1, ir6);
        check("ch6 rr next in_ready", 32'(ir6), 32'h02);
        check("ch6 rr next out_ch", 32'(r6_out_ch), 32'd1);
`ifdef MX_RR_SEL_CNT_EN
        check("ch6 xfer_cnt", 32'(r6_xfer_cnt), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
